// File: rtl/dynamixel_status_parser_if.sv
// Byte-stream, arm and result signals of the Dynamixel status packet parser.
interface dynamixel_status_parser_if;
    logic        arm;
    logic [7:0]  expected_id;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        busy;
    logic        done;
    logic        ok;
    logic [2:0]  err_code;
    logic [7:0]  status_id;
    logic [7:0]  status_len;
    logic [7:0]  status_error;
    logic [31:0] params;

    modport master (
        output arm, expected_id, rx_valid, rx_data,
        input  busy, done, ok, err_code, status_id, status_len, status_error, params
    );

    modport slave (
        input  arm, expected_id, rx_valid, rx_data,
        output busy, done, ok, err_code, status_id, status_len, status_error, params
    );
endinterface

// File: rtl/dynamixel_status_parser.sv
// Dynamixel status packet parser: header resync, field capture, checksum,
// responder ID check and whole-packet timeout. Results held until next arm.
module dynamixel_status_parser #(
    parameter int unsigned TIMEOUT_CYCLES = 500000,
    parameter int unsigned MAX_PARAMS     = 4
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    dynamixel_status_parser_if.slave  bus
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [3:0] {
        IDLE, HDR1, HDR2, GET_ID, GET_LEN, GET_ERR, GET_PARAM, GET_CHK, FINISH
    } state_t;

    state_t      state_q;
    logic [TW-1:0] tmo_q;
    logic [1:0]  idx_q;
    logic [7:0]  sum_q;
    logic [7:0]  exp_id_q;
    logic        busy_q;
    logic        done_q;
    logic        ok_q;
    logic [2:0]  err_q;
    logic [7:0]  id_q;
    logic [7:0]  len_q;
    logic [7:0]  errb_q;
    logic [31:0] params_q;

    logic [TW-1:0] tmo_d;
    logic        tmo_hit;
    logic [7:0]  sum_d;
    logic [7:0]  nparam;
    logic        len_bad;
    logic        last_param;

    // Next counter/sum values and field-derived decisions.
    always_comb begin
        tmo_d      = tmo_q + 1'b1;
        tmo_hit    = (tmo_d == TW'(TIMEOUT_CYCLES));
        sum_d      = sum_q + bus.rx_data;
        nparam     = len_q - 8'd2;
        len_bad    = (bus.rx_data < 8'd2) || (bus.rx_data > 8'(MAX_PARAMS + 2));
        last_param = (({6'd0, idx_q} + 8'd1) == nparam);
    end

    // Packet FSM with registered outputs; arm restarts from any state.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= IDLE;
            tmo_q    <= '0;
            idx_q    <= '0;
            sum_q    <= '0;
            exp_id_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ok_q     <= 1'b0;
            err_q    <= '0;
            id_q     <= '0;
            len_q    <= '0;
            errb_q   <= '0;
            params_q <= '0;
        end else if (bus.arm) begin
            state_q  <= HDR1;
            exp_id_q <= bus.expected_id;
            tmo_q    <= '0;
            idx_q    <= '0;
            sum_q    <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            ok_q     <= 1'b0;
            err_q    <= '0;
            id_q     <= '0;
            len_q    <= '0;
            errb_q   <= '0;
            params_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (state_q != IDLE) tmo_q <= tmo_d;
            if (state_q == FINISH) begin
                state_q <= IDLE;
            end else if (state_q != IDLE) begin
                // Terminal count takes precedence over a byte in the same cycle.
                if (tmo_hit) begin
                    state_q <= FINISH;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    err_q   <= 3'd1;
                end else if (bus.rx_valid) begin
                    case (state_q)
                        HDR1: if (bus.rx_data == 8'hFF) state_q <= HDR2;
                        HDR2: state_q <= (bus.rx_data == 8'hFF) ? GET_ID : HDR1;
                        GET_ID: begin
                            if (bus.rx_data != 8'hFF) begin
                                id_q    <= bus.rx_data;
                                sum_q   <= bus.rx_data;
                                state_q <= GET_LEN;
                            end
                        end
                        GET_LEN: begin
                            len_q <= bus.rx_data;
                            sum_q <= sum_d;
                            if (len_bad) begin
                                state_q <= FINISH;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                err_q   <= 3'd4;
                            end else begin
                                state_q <= GET_ERR;
                            end
                        end
                        GET_ERR: begin
                            errb_q  <= bus.rx_data;
                            sum_q   <= sum_d;
                            state_q <= (nparam == 8'd0) ? GET_CHK : GET_PARAM;
                        end
                        GET_PARAM: begin
                            params_q[{idx_q, 3'b000} +: 8] <= bus.rx_data;
                            sum_q <= sum_d;
                            idx_q <= idx_q + 1'b1;
                            if (last_param) state_q <= GET_CHK;
                        end
                        GET_CHK: begin
                            state_q <= FINISH;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            if (bus.rx_data != ~sum_q) begin
                                err_q <= 3'd2;
                            end else if (id_q != exp_id_q) begin
                                err_q <= 3'd3;
                            end else begin
                                ok_q  <= 1'b1;
                                err_q <= 3'd0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.ok           = ok_q;
    assign bus.err_code     = err_q;
    assign bus.status_id    = id_q;
    assign bus.status_len   = len_q;
    assign bus.status_error = errb_q;
    assign bus.params       = params_q;
endmodule

// File: tb/tb_dynamixel_status_parser.sv
// Scoreboard bench for dynamixel_status_parser: directed and random packets
// against a byte-list reference parser.
module tb_dynamixel_status_parser;
    localparam int unsigned TMO  = 200;
    localparam int unsigned MAXP = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    dynamixel_status_parser_if bus ();

    dynamixel_status_parser #(.TIMEOUT_CYCLES(TMO), .MAX_PARAMS(MAXP)) dut (
        .clk_i   (clk),
        .reset_ni(reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Cycle counter used for latency expectations.
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        ok;
        logic [2:0]  err;
        logic [7:0]  id;
        logic [7:0]  len;
        logic [7:0]  errb;
        logic [31:0] params;
        int          term;   // index of the byte that ends the packet, -1 = timeout
    } res_t;

    typedef struct {
        res_t r;
        int   done_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t me;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Reference parser: locate the first FF FF pair, skip extra FFs, then read
    // ID, length, error, N params and checksum as plain list positions.
    function automatic res_t model(input logic [7:0] b[$], input logic [7:0] eid);
        res_t r;
        int i;
        int n;
        logic [7:0] s;
        r.ok = 1'b0; r.err = 3'd1; r.id = 8'h00; r.len = 8'h00;
        r.errb = 8'h00; r.params = 32'h0; r.term = -1;
        i = 0;
        while (i + 1 < b.size() && !(b[i] == 8'hFF && b[i+1] == 8'hFF)) i++;
        if (i + 1 >= b.size()) return r;
        i += 2;
        while (i < b.size() && b[i] == 8'hFF) i++;
        if (i >= b.size()) return r;
        r.id = b[i]; i++;
        if (i >= b.size()) return r;
        r.len = b[i];
        if (int'(r.len) < 2 || int'(r.len) > int'(MAXP) + 2) begin
            r.err = 3'd4; r.term = i; return r;
        end
        i++;
        if (i >= b.size()) return r;
        r.errb = b[i]; i++;
        n = int'(r.len) - 2;
        s = r.id + r.len + r.errb;
        for (int k = 0; k < n; k++) begin
            if (i >= b.size()) return r;
            r.params[8*k +: 8] = b[i];
            s = s + b[i];
            i++;
        end
        if (i >= b.size()) return r;
        r.term = i;
        if (b[i] != ~s)      r.err = 3'd2;
        else if (r.id != eid) r.err = 3'd3;
        else begin r.ok = 1'b1; r.err = 3'd0; end
        return r;
    endfunction

    // Monitor: every done pulse pops one expectation and compares all results.
    always @(negedge clk) begin
        if (bus.done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1, expected no done (cycle %0d)", cyc);
            end else begin
                me = sb.pop_front();
                chk("done_cycle", 32'(cyc), 32'(me.done_cyc));
                chk("ok", 32'(bus.ok), 32'(me.r.ok));
                chk("err_code", 32'(bus.err_code), 32'(me.r.err));
                chk("status_id", 32'(bus.status_id), 32'(me.r.id));
                chk("status_len", 32'(bus.status_len), 32'(me.r.len));
                chk("status_error", 32'(bus.status_error), 32'(me.r.errb));
                chk("params", bus.params, me.r.params);
                chk("busy_at_done", 32'(bus.busy), 32'd0);
            end
        end
    end

    task automatic run_txn(input logic [7:0] b[$], input logic [7:0] eid, input int maxgap);
        res_t r;
        exp_t e;
        int last;
        r = model(b, eid);
        e.r = r;
        @(negedge clk);
        bus.arm = 1'b1;
        bus.expected_id = eid;
        if (r.term < 0) begin
            e.done_cyc = cyc + int'(TMO) + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.arm = 1'b0;
        chk("busy_after_arm", 32'(bus.busy), 32'd1);
        last = (r.term < 0) ? b.size() - 1 : r.term;
        for (int i = 0; i <= last; i++) begin
            if (i == r.term) begin
                e.done_cyc = cyc + 1;
                sb.push_back(e);
            end
            bus.rx_valid = 1'b1;
            bus.rx_data  = b[i];
            @(negedge clk);
            bus.rx_valid = 1'b0;
            if (i < last) repeat ($urandom_range(maxgap, 0)) @(negedge clk);
        end
        for (int w = 0; w < int'(TMO) + 20; w++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk("done_arrived", 32'(sb.size()), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic send_raw(input logic [7:0] b[$]);
        foreach (b[i]) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = b[i];
            @(negedge clk);
            bus.rx_valid = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pk[$];
        logic [7:0] eid, id, len, s, v;
        bus.arm = 1'b0; bus.expected_id = 8'h00; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_ok", 32'(bus.ok), 32'd0);
        chk("rst_err", 32'(bus.err_code), 32'd0);
        chk("rst_id", 32'(bus.status_id), 32'd0);
        chk("rst_len", 32'(bus.status_len), 32'd0);
        chk("rst_errb", 32'(bus.status_error), 32'd0);
        chk("rst_params", bus.params, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        pk = {8'hFF, 8'hFF, 8'h01, 8'h04, 8'h00, 8'h20, 8'h03, 8'hD7};
        run_txn(pk, 8'h01, 0);
        chk("p1_params_held", bus.params, 32'h0000_0320);
        chk("p1_ok_held", 32'(bus.ok), 32'd1);

        pk = {8'h55, 8'hFF, 8'h12, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h02, 8'h00, 8'hFC};
        run_txn(pk, 8'h01, 1);
        chk("p2_ok_held", 32'(bus.ok), 32'd1);

        pk = {8'hFF, 8'hFF, 8'h01, 8'h04, 8'h00, 8'h20, 8'h03, 8'hD6};
        run_txn(pk, 8'h01, 0);
        chk("p3_err_held", 32'(bus.err_code), 32'd2);

        pk = {8'hFF, 8'hFF, 8'h02, 8'h04, 8'h00, 8'h20, 8'h03, 8'hD6};
        run_txn(pk, 8'h01, 0);
        chk("p4_err_held", 32'(bus.err_code), 32'd3);

        pk = {8'hFF, 8'hFF, 8'h01, 8'h07};
        run_txn(pk, 8'h01, 0);
        chk("p5_err_held", 32'(bus.err_code), 32'd4);

        pk = {8'hFF, 8'hFF, 8'h01};
        run_txn(pk, 8'h01, 0);
        chk("p6_err_held", 32'(bus.err_code), 32'd1);
        chk("p6_id_held", 32'(bus.status_id), 32'h01);

        // Aborted transaction: no expectation queued, so any done for it fails.
        @(negedge clk);
        bus.arm = 1'b1; bus.expected_id = 8'h01;
        @(negedge clk);
        bus.arm = 1'b0;
        pk = {8'hFF, 8'hFF, 8'h01, 8'h04, 8'h00};
        send_raw(pk);
        pk = {8'hFF, 8'hFF, 8'h01, 8'h04, 8'h00, 8'h20, 8'h03, 8'hD7};
        run_txn(pk, 8'h01, 0);

        // Asynchronous reset in the middle of a packet.
        @(negedge clk);
        bus.arm = 1'b1; bus.expected_id = 8'h01;
        @(negedge clk);
        bus.arm = 1'b0;
        pk = {8'hFF, 8'hFF, 8'h01, 8'h04, 8'h00, 8'h20};
        send_raw(pk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_id", 32'(bus.status_id), 32'd0);
        chk("arst_len", 32'(bus.status_len), 32'd0);
        chk("arst_params", bus.params, 32'd0);
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("arst_still_idle", 32'(bus.busy), 32'd0);

        for (int t = 0; t < 40; t++) begin
            pk.delete();
            eid = 8'($urandom_range(254, 0));
            repeat ($urandom_range(3, 0)) pk.push_back(8'($urandom_range(254, 0)));
            if ($urandom_range(1, 0) == 1) begin
                pk.push_back(8'hFF);
                pk.push_back(8'($urandom_range(254, 0)));
            end
            pk.push_back(8'hFF);
            pk.push_back(8'hFF);
            repeat ($urandom_range(2, 0)) pk.push_back(8'hFF);
            id = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(254, 0)) : eid;
            if ($urandom_range(7, 0) == 0) begin
                len = ($urandom_range(1, 0) == 1) ? 8'($urandom_range(1, 0))
                                                  : 8'($urandom_range(255, MAXP + 3));
            end else begin
                len = 8'($urandom_range(MAXP + 2, 2));
            end
            pk.push_back(id);
            pk.push_back(len);
            if (int'(len) >= 2 && int'(len) <= int'(MAXP) + 2) begin
                v = 8'($urandom_range(255, 0));
                pk.push_back(v);
                s = id + len + v;
                for (int k = 0; k < int'(len) - 2; k++) begin
                    v = 8'($urandom_range(255, 0));
                    pk.push_back(v);
                    s = s + v;
                end
                v = ~s;
                if ($urandom_range(5, 0) == 0) v = v ^ 8'($urandom_range(255, 1));
                pk.push_back(v);
                if ($urandom_range(9, 0) == 0) void'(pk.pop_back());
            end
            run_txn(pk, eid, 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
